// File: rtl/gcd_pkg.sv
// gcd_pkg: shared types and defaults for the GCD job sequencer.
//   NBITS_DEF        default operand/result width
//   gcd_seq_state_t  sequencer FSM state encoding
//   gcd_pair_t       operand pair at the default width
package gcd_pkg;

  localparam int NBITS_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } gcd_seq_state_t;

  typedef struct packed {
    logic [NBITS_DEF-1:0] x;
    logic [NBITS_DEF-1:0] y;
  } gcd_pair_t;

endpackage

// File: rtl/gcd_op_fifo.sv
// gcd_op_fifo: operand-pair FIFO, DEPTH entries of W bits, valid/ready on both sides.
//   clk, rst        clock, asynchronous active-low reset
//   push_valid_i    write request; accepted when push_ready_o is high
//   push_ready_o    not full
//   push_data_i     write data
//   pop_ready_i     read request; honoured only when not empty
//   pop_data_o      head entry
//   count_o         number of stored entries
//   full_o/empty_o  occupancy flags
module gcd_op_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid_i,
  output logic                     push_ready_o,
  input  logic [W-1:0]             push_data_i,
  input  logic                     pop_ready_i,
  output logic [W-1:0]             pop_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push;
  logic          pop;

  assign full_o       = (count_q == (AW+1)'(DEPTH));
  assign empty_o      = (count_q == '0);
  assign push_ready_o = ~full_o;
  assign push         = push_valid_i & ~full_o;
  assign pop          = pop_ready_i & ~empty_o;
  assign pop_data_o   = mem_q[rd_ptr_q];
  assign count_o      = count_q;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/gcd_job_sequencer.sv
// gcd_job_sequencer: buffers operand pairs, issues them one at a time to a GCD core,
// and returns tagged results. Zero operands bypass the core; a watchdog ends a stuck job.
//   clk, rst                       clock, asynchronous active-low reset
//   in_valid/in_ready/in_x/in_y    operand stream (in_ready = FIFO not full)
//   core_xi/core_yi/core_start     core request (registered; start is a one-cycle pulse)
//   core_rdy/core_xo               core handshake and result
//   out_valid/out_ready            result stream, held until accepted
//   out_gcd/out_x/out_y/out_err    result, echoed operands, timeout flag
//   busy                           job in flight or FIFO non-empty
//
// state | meaning
// IDLE  | waiting for a queued pair; pops it when bypassable or core ready
// ISSUE | core_start high for this cycle; timer and seen_low cleared
// WAIT  | core running; capture on rdy rising after a low, or time out
// OUT   | result presented until out_ready
module gcd_job_sequencer
  import gcd_pkg::*;
#(
  parameter int NBITS   = NBITS_DEF,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] in_x,
  input  logic [NBITS-1:0] in_y,
  output logic [NBITS-1:0] core_xi,
  output logic [NBITS-1:0] core_yi,
  output logic             core_start,
  input  logic             core_rdy,
  input  logic [NBITS-1:0] core_xo,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] out_gcd,
  output logic [NBITS-1:0] out_x,
  output logic [NBITS-1:0] out_y,
  output logic             out_err,
  output logic             busy
);

  localparam int TW = $clog2(TIMEOUT+1);

  gcd_seq_state_t          state_q;
  logic [NBITS-1:0]        core_xi_q, core_yi_q;
  logic                    core_start_q;
  logic                    seen_low_q;
  logic [TW-1:0]           timer_q;
  logic                    out_valid_q, out_err_q;
  logic [NBITS-1:0]        out_gcd_q, out_x_q, out_y_q;

  logic [2*NBITS-1:0]      head;
  logic [NBITS-1:0]        head_x, head_y;
  logic                    head_zero;
  logic                    fifo_pop;
  logic                    fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0]  fifo_count;

  assign head_x    = head[2*NBITS-1:NBITS];
  assign head_y    = head[NBITS-1:0];
  assign head_zero = (head_x == '0) || (head_y == '0);
  // A non-bypass pair stays queued while the core is still busy.
  assign fifo_pop  = (state_q == IDLE) && !fifo_empty && (head_zero || core_rdy);

  gcd_op_fifo #(.W(2*NBITS), .DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_valid_i (in_valid),
    .push_ready_o (in_ready),
    .push_data_i  ({in_x, in_y}),
    .pop_ready_i  (fifo_pop),
    .pop_data_o   (head),
    .count_o      (fifo_count),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      core_xi_q    <= '0;
      core_yi_q    <= '0;
      core_start_q <= 1'b0;
      seen_low_q   <= 1'b0;
      timer_q      <= '0;
      out_valid_q  <= 1'b0;
      out_err_q    <= 1'b0;
      out_gcd_q    <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
    end else begin
      core_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fifo_pop) begin
            if (head_zero) begin
              out_gcd_q   <= head_x | head_y;
              out_x_q     <= head_x;
              out_y_q     <= head_y;
              out_err_q   <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= OUT;
            end else begin
              core_xi_q    <= head_x;
              core_yi_q    <= head_y;
              core_start_q <= 1'b1;
              state_q      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          seen_low_q <= 1'b0;
          timer_q    <= '0;
          state_q    <= WAIT;
        end
        WAIT: begin
          timer_q <= timer_q + TW'(1);
          if (!core_rdy) seen_low_q <= 1'b1;
          // Capture is checked first so it wins over a coincident timeout.
          if (seen_low_q && core_rdy) begin
            out_gcd_q   <= core_xo;
            out_x_q     <= core_xi_q;
            out_y_q     <= core_yi_q;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end else if (timer_q == TW'(TIMEOUT)) begin
            out_gcd_q   <= '0;
            out_x_q     <= core_xi_q;
            out_y_q     <= core_yi_q;
            out_err_q   <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign core_xi    = core_xi_q;
  assign core_yi    = core_yi_q;
  assign core_start = core_start_q;
  assign out_valid  = out_valid_q;
  assign out_gcd    = out_gcd_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign out_err    = out_err_q;
  assign busy       = (state_q != IDLE) || (fifo_count != '0) || fifo_full;

endmodule

// File: tb/tb_gcd_job_sequencer.sv
module tb_gcd_job_sequencer;
  import gcd_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_x = '0;
  logic [7:0] in_y = '0;
  logic [7:0] core_xi, core_yi;
  logic       core_start;
  logic       core_rdy;
  logic [7:0] core_xo;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_gcd, out_x, out_y;
  logic       out_err;
  logic       busy;

  int n_asserts = 0;
  int n_fail    = 0;
  int start_cnt = 0;
  int mode      = 0;   // 0 normal core, 1 rdy never drops, 2 rdy stuck low
  int lat       = 5;
  int cnt       = 0;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] x;
    logic [7:0] y;
    logic       e;
  } res_t;

  res_t got[$];
  res_t prev;
  bit   prev_hold = 1'b0;

  gcd_job_sequencer #(.NBITS(8), .DEPTH(4), .TIMEOUT(20)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .core_xi    (core_xi),
    .core_yi    (core_yi),
    .core_start (core_start),
    .core_rdy   (core_rdy),
    .core_xo    (core_xo),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_gcd    (out_gcd),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_err    (out_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gcd_f(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, t;
    a = a_in;
    b = b_in;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Behavioural GCD core
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_rdy <= 1'b1;
      core_xo  <= '0;
      cnt      <= 0;
    end else if (core_start) begin
      if (mode == 0) begin
        core_rdy <= 1'b0;
        cnt      <= lat;
      end else if (mode == 2) begin
        core_rdy <= 1'b0;
      end
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        core_rdy <= 1'b1;
        core_xo  <= gcd_f(core_xi, core_yi);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (core_start) start_cnt++;
  end

  // Output monitor: stability while stalled, and collection of accepted results
  always @(negedge clk) begin
    if (prev_hold && rst)
      chk("out_stable", {out_valid, out_gcd, out_x, out_y, out_err}, {1'b1, prev});
    if (rst && out_valid && out_ready)
      got.push_back({out_gcd, out_x, out_y, out_err});
    prev_hold = rst && out_valid && !out_ready;
    prev      = {out_gcd, out_x, out_y, out_err};
  end

  task automatic push(input logic [7:0] x, input logic [7:0] y);
    int n;
    n = 0;
    in_x = x;
    in_y = y;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("push_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    @(negedge clk);
    while (!core_start && n < 60) begin
      n++;
      @(negedge clk);
    end
    chk("start_seen", core_start, 1);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 80) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic expect_res(input string tag, input logic [7:0] g, input logic [7:0] x,
                            input logic [7:0] y, input logic e);
    res_t r;
    int   n;
    n = 0;
    while (got.size() == 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_avail"}, (got.size() > 0), 1);
    if (got.size() > 0) begin
      r = got.pop_front();
      chk({tag, "_gcd"}, r.g, g);
      chk({tag, "_x"},   r.x, x);
      chk({tag, "_y"},   r.y, y);
      chk({tag, "_err"}, r.e, e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, n;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",   in_ready,   1);
    chk("rst_out_valid",  out_valid,  0);
    chk("rst_core_start", core_start, 0);
    chk("rst_busy",       busy,       0);
    chk("rst_out_gcd",    out_gcd,    0);
    chk("rst_out_err",    out_err,    0);
    chk("rst_core_xi",    core_xi,    0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Normal job through the core
    mode = 0; lat = 5; out_ready = 1'b1;
    s0 = start_cnt;
    push(8'd12, 8'd18);
    wait_start();
    chk("t1_xi", core_xi, 12);
    chk("t1_yi", core_yi, 18);
    @(negedge clk);
    chk("t1_pulse_len", core_start, 0);
    expect_res("t1", 8'd6, 8'd12, 8'd18, 1'b0);
    repeat (3) @(negedge clk);
    chk("t1_starts", start_cnt - s0, 1);

    // Zero-operand bypass
    out_ready = 1'b0;
    s0 = start_cnt;
    @(posedge clk); #1;
    in_x = 8'd0; in_y = 8'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_valid_early", out_valid, 0);
    @(negedge clk);
    chk("bp_valid_lat", out_valid, 1);
    chk("bp_gcd_lat",   out_gcd,   9);
    @(posedge clk); #1;
    push(8'd7, 8'd0);
    out_ready = 1'b1;
    expect_res("bp1", 8'd9, 8'd0, 8'd9, 1'b0);
    expect_res("bp2", 8'd7, 8'd7, 8'd0, 1'b0);
    chk("bp_no_start", start_cnt - s0, 0);

    // FIFO full: 1 in flight plus 4 queued
    @(posedge clk); #1;
    out_ready = 1'b0;
    push(8'd0, 8'd1);
    push(8'd0, 8'd2);
    push(8'd0, 8'd3);
    push(8'd0, 8'd4);
    @(negedge clk);
    chk("full_ready_before", in_ready, 1);
    @(posedge clk); #1;
    push(8'd0, 8'd5);
    @(negedge clk);
    chk("full_ready", in_ready, 0);
    chk("full_busy",  busy,     1);
    @(posedge clk); #1;
    in_x = 8'd0; in_y = 8'd6; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    expect_res("full1", 8'd1, 8'd0, 8'd1, 1'b0);
    expect_res("full2", 8'd2, 8'd0, 8'd2, 1'b0);
    expect_res("full3", 8'd3, 8'd0, 8'd3, 1'b0);
    expect_res("full4", 8'd4, 8'd0, 8'd4, 1'b0);
    expect_res("full5", 8'd5, 8'd0, 8'd5, 1'b0);
    repeat (6) @(negedge clk);
    chk("full_no_extra", got.size(), 0);

    // Timeout with rdy never dropping
    @(posedge clk); #1;
    mode = 1;
    push(8'd3, 8'd6);
    wait_start();
    wait_valid(n);
    chk("to_hi_lat", (n >= 21 && n <= 22), 1);
    expect_res("to_hi", 8'd0, 8'd3, 8'd6, 1'b1);

    // Timeout with rdy stuck low
    @(posedge clk); #1;
    mode = 2;
    push(8'd4, 8'd8);
    wait_start();
    wait_valid(n);
    chk("to_lo_lat", (n >= 21 && n <= 22), 1);
    expect_res("to_lo", 8'd0, 8'd4, 8'd8, 1'b1);

    // Core still busy: a non-zero pair must wait in the FIFO
    @(posedge clk); #1;
    s0 = start_cnt;
    push(8'd5, 8'd5);
    repeat (6) @(negedge clk);
    chk("stall_no_start", start_cnt - s0, 0);
    chk("stall_busy",     busy,           1);
    #2 rst = 1'b0;
    #1;
    chk("stall_rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Reset during WAIT
    @(posedge clk); #1;
    push(8'd10, 8'd15);
    wait_start();
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("wrst_start", core_start, 0);
    chk("wrst_valid", out_valid,  0);
    chk("wrst_busy",  busy,       0);
    chk("wrst_ready", in_ready,   1);
    chk("wrst_xi",    core_xi,    0);
    @(posedge clk); #1;
    rst = 1'b1;
    mode = 0; lat = 3;
    @(posedge clk); #1;
    push(8'd9, 8'd6);
    expect_res("wrst_next", 8'd3, 8'd9, 8'd6, 1'b0);
    repeat (4) @(negedge clk);
    chk("wrst_no_extra", got.size(), 0);

    // Random out_ready back-pressure
    @(posedge clk); #1;
    out_ready = 1'b0;
    push(8'd0,  8'd4);
    push(8'd8,  8'd12);
    push(8'd21, 8'd14);
    push(8'd5,  8'd0);
    push(8'd9,  8'd27);
    for (int i = 0; i < 600 && got.size() < 5; i++) begin
      @(posedge clk); #1;
      out_ready = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("rnd_count", got.size(), 5);
    expect_res("rnd1", 8'd4, 8'd0,  8'd4,  1'b0);
    expect_res("rnd2", 8'd4, 8'd8,  8'd12, 1'b0);
    expect_res("rnd3", 8'd7, 8'd21, 8'd14, 1'b0);
    expect_res("rnd4", 8'd5, 8'd5,  8'd0,  1'b0);
    expect_res("rnd5", 8'd9, 8'd9,  8'd27, 1'b0);
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("rnd_no_dup", got.size(), 0);
    chk("rnd_idle",   busy,       0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
